// File: rtl/box_pkg.sv
// Shared constants, FSM encoding and coordinate helpers for the box overlay controller.
package box_pkg;
  localparam int COORD_W   = 10;
  localparam int NUM_BTN   = 5;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_MODE  = 4;

  typedef enum logic {WAIT_EDGE = 1'b0, UPDATE = 1'b1} state_t;

  // Limits for the default 640x480 / 100x100 geometry.
  localparam int X_MAX = 640 - 100;
  localparam int Y_MAX = 480 - 100;

  function automatic logic [COORD_W-1:0] coord_max(input int active, input int box);
    return COORD_W'(active - box);
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [COORD_W:0] v,
                                                     input logic [COORD_W-1:0] lim);
    if (v < 0)                      return '0;
    else if (v > $signed({1'b0, lim})) return lim;
    else                            return v[COORD_W-1:0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one button.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box position controller: debounced buttons, manual/bounce motion,
// clamped to the active area, plus a registered per-pixel in_box flag.
module box_motion_ctrl
  import box_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_W     = 100,
  parameter int BOX_H     = 100,
  parameter int STEP      = 1,
  parameter int DB_CYCLES = 250000
) (
  input  logic               clk_25mhz,
  input  logic               rst,
  input  logic               vsync,
  input  logic [4:0]         btn_raw,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic               in_box,
  output logic               bounce_mode,
  output logic               frame_tick
);
  localparam logic [COORD_W-1:0]      X_LIM  = coord_max(H_ACTIVE, BOX_W);
  localparam logic [COORD_W-1:0]      Y_LIM  = coord_max(V_ACTIVE, BOX_H);
  localparam logic [COORD_W-1:0]      X_HOME = COORD_W'((H_ACTIVE - BOX_W) / 2);
  localparam logic [COORD_W-1:0]      Y_HOME = COORD_W'((V_ACTIVE - BOX_H) / 2);
  localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);
  localparam logic signed [COORD_W:0] ZERO   = '0;

  logic [NUM_BTN-1:0] btn_lvl;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .raw       (btn_raw[i]),
      .level     (btn_lvl[i])
    );
  end

  state_t                  state;
  logic                    vsync_q, mode_q, dx, dy;
  logic signed [COORD_W:0] sx, sy, nx, ny;
  logic                    flip_x, flip_y;

  assign sx = $signed({1'b0, box_x});
  assign sy = $signed({1'b0, box_y});

  // Unclamped next position; clamping and reflection happen on commit.
  always_comb begin
    nx     = sx;
    ny     = sy;
    flip_x = 1'b0;
    flip_y = 1'b0;
    if (bounce_mode) begin
      nx     = dx ? sx + STEP_S : sx - STEP_S;
      ny     = dy ? sy + STEP_S : sy - STEP_S;
      flip_x = dx ? (nx >= $signed({1'b0, X_LIM})) : (nx <= ZERO);
      flip_y = dy ? (ny >= $signed({1'b0, Y_LIM})) : (ny <= ZERO);
    end else if (btn_lvl[BTN_RIGHT]) nx = sx + STEP_S;
    else if (btn_lvl[BTN_LEFT])      nx = sx - STEP_S;
    else if (btn_lvl[BTN_UP])        ny = sy - STEP_S;
    else if (btn_lvl[BTN_DOWN])      ny = sy + STEP_S;
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state       <= WAIT_EDGE;
      vsync_q     <= 1'b0;
      mode_q      <= 1'b0;
      box_x       <= X_HOME;
      box_y       <= Y_HOME;
      dx          <= 1'b1;
      dy          <= 1'b1;
      bounce_mode <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      mode_q     <= btn_lvl[BTN_MODE];
      frame_tick <= 1'b0;
      // A toggle landing on the UPDATE cycle takes effect for the next frame.
      if (btn_lvl[BTN_MODE] && !mode_q) bounce_mode <= ~bounce_mode;
      case (state)
        WAIT_EDGE: if (vsync && !vsync_q) state <= UPDATE;
        UPDATE: begin
          state      <= WAIT_EDGE;
          frame_tick <= 1'b1;
          box_x      <= clamp_coord(nx, X_LIM);
          box_y      <= clamp_coord(ny, Y_LIM);
          if (flip_x) dx <= ~dx;
          if (flip_y) dy <= ~dy;
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

  logic [COORD_W:0] x_end, y_end;
  assign x_end = {1'b0, box_x} + (COORD_W+1)'(BOX_W);
  assign y_end = {1'b0, box_y} + (COORD_W+1)'(BOX_H);

  always_ff @(posedge clk_25mhz) begin
    if (rst) in_box <= 1'b0;
    else     in_box <= (x >= box_x) && ({1'b0, x} < x_end) &&
                       (y >= box_y) && ({1'b0, y} < y_end);
  end
endmodule

// File: tb/tb_box_motion_ctrl.sv
// Scoreboard bench for box_motion_ctrl: frames push expected positions, a monitor checks each frame_tick.
module tb_box_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [9:0] x = '0, y = '0;
  logic [9:0] box_x, box_y;
  logic       in_box, bounce_mode, frame_tick;

  box_motion_ctrl #(.DB_CYCLES(16)) dut (
    .clk_25mhz   (clk),
    .rst         (rst),
    .vsync       (vsync),
    .btn_raw     (btn_raw),
    .x           (x),
    .y           (y),
    .box_x       (box_x),
    .box_y       (box_y),
    .in_box      (in_box),
    .bounce_mode (bounce_mode),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0, failures = 0;
  bit  done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct { int tcyc; int ex; int ey; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every frame_tick must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!rst && frame_tick) begin
      if (sb.size() == 0) chk("tick_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("tick_cycle", cyc, mon_e.tcyc);
        chk("frame_box_x", box_x, mon_e.ex);
        chk("frame_box_y", box_y, mon_e.ey);
      end
    end
  end

  task automatic send_frame(input int ex, input int ey);
    exp_t e;
    @(posedge clk); #1;
    vsync = 1'b1;
    e.tcyc = cyc + 2; e.ex = ex; e.ey = ey;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic set_btn(input logic [4:0] b);
    @(posedge clk); #1 btn_raw = b;
    repeat (25) @(posedge clk);
  endtask

  task automatic pix(input int px, input int py, input logic exp, input string nm);
    @(posedge clk); #1 x = 10'(px); y = 10'(py);
    @(posedge clk);
    @(negedge clk) chk(nm, in_box, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_box_x", box_x, 270);
    chk("rst_box_y", box_y, 190);
    chk("rst_bounce", bounce_mode, 0);
    chk("rst_in_box", in_box, 0);
    chk("rst_tick", frame_tick, 0);

    repeat (3) send_frame(270, 190);

    pix(270, 190, 1'b1, "inbox_topleft");
    pix(369, 289, 1'b1, "inbox_botright");
    pix(370, 190, 1'b0, "inbox_right_out");
    pix(269, 200, 1'b0, "inbox_left_out");

    // Short glitch on left must never be accepted.
    @(posedge clk); #1 btn_raw = 5'b00010;
    repeat (10) @(posedge clk);
    #1 btn_raw = 5'b00000;
    repeat (30) @(posedge clk);
    repeat (3) send_frame(270, 190);

    // Right + up: right wins, up ignored.
    set_btn(5'b00101);
    for (int v = 271; v <= 539; v++) send_frame(v, 190);
    send_frame(540, 190);
    send_frame(540, 190);

    set_btn(5'b00100);
    for (int v = 189; v >= 0; v--) send_frame(540, v);
    send_frame(540, 0);

    set_btn(5'b00010);
    send_frame(539, 0);
    send_frame(538, 0);
    set_btn(5'b00000);

    set_btn(5'b10000);
    chk("mode_toggled", bounce_mode, 1);
    repeat (40) @(posedge clk);
    @(negedge clk) chk("mode_held", bounce_mode, 1);
    set_btn(5'b00000);
    @(negedge clk) chk("mode_released", bounce_mode, 1);

    send_frame(539, 1);
    send_frame(540, 2);
    send_frame(539, 3);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_box_x", box_x, 270);
    chk("rst2_box_y", box_y, 190);
    chk("rst2_bounce", bounce_mode, 0);
    chk("rst2_tick", frame_tick, 0);
    send_frame(270, 190);

    repeat (10) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    if (!done) begin
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
    end
  end
endmodule
